// File: rtl/lector_teclado_if.sv
// Keypad bus: row sense lines in, column drive and decoded key out.
// Combinational bundle only, so it adds no latency.
// No backpressure: valido is a one-clk strobe that the consumer must take.
interface lector_teclado_if;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [3:0] tecla;
    logic       valido;
    logic       presionada;

    modport master (
        input  filas,
        output columnas,
        output tecla,
        output valido,
        output presionada
    );

    modport slave (
        output filas,
        input  columnas,
        input  tecla,
        input  valido,
        input  presionada
    );
endinterface

// File: rtl/lector_teclado.sv
// 4x4 matrix keypad scanner with tick-based press/release debounce.
// Latency: DEB_TICKS scan ticks from the first low sample to valido (plus 2 clk sync).
// No backpressure: valido is a single-clk strobe; tecla holds until the next press.
module lector_teclado #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_TICKS = 4
) (
    input  logic         clk,
    input  logic         rst,
    lector_teclado_if.master bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {BARRIDO, REBOTE, SOSTENIDA} estado_t;

    logic [3:0]    filas_m, filas_s;
    logic [CW-1:0] div;
    logic          tick;

    estado_t       estado, estado_n;
    logic [1:0]    col, col_n;
    logic [1:0]    fila, fila_n;
    logic [3:0]    cuenta, cuenta_n;
    logic [3:0]    tecla_q, tecla_n;
    logic          valido_q, valido_n;
    logic          pres_q, pres_n;

    logic          hay_baja;
    logic [1:0]    fila_baja;
    logic          fila_sel_alta;

    // Rows idle high, so the synchronizer resets to all-ones to avoid a false press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filas_m <= 4'hF;
            filas_s <= 4'hF;
        end else begin
            filas_m <= bus.filas;
            filas_s <= filas_m;
        end
    end

    assign tick = (div == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div <= '0;
        else if (tick) div <= '0;
        else           div <= div + 1'b1;
    end

    always_comb begin
        hay_baja  = ~&filas_s;
        fila_baja = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!filas_s[i]) fila_baja = 2'(i);
        end
    end

    assign fila_sel_alta = filas_s[fila];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado   <= BARRIDO;
            col      <= 2'd0;
            fila     <= 2'd0;
            cuenta   <= 4'd0;
            tecla_q  <= 4'd0;
            valido_q <= 1'b0;
            pres_q   <= 1'b0;
        end else begin
            estado   <= estado_n;
            col      <= col_n;
            fila     <= fila_n;
            cuenta   <= cuenta_n;
            tecla_q  <= tecla_n;
            valido_q <= valido_n;
            pres_q   <= pres_n;
        end
    end

    always_comb begin
        estado_n = estado;
        col_n    = col;
        fila_n   = fila;
        cuenta_n = cuenta;
        tecla_n  = tecla_q;
        valido_n = 1'b0;
        pres_n   = pres_q;
        if (tick) begin
            unique case (estado)
                BARRIDO: begin
                    if (hay_baja) begin
                        fila_n   = fila_baja;
                        cuenta_n = 4'd1;
                        estado_n = REBOTE;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end
                REBOTE: begin
                    if (fila_sel_alta) begin
                        cuenta_n = 4'd0;
                        col_n    = col + 2'd1;
                        estado_n = BARRIDO;
                    end else if (cuenta == 4'(DEB_TICKS - 1)) begin
                        cuenta_n = 4'd0;
                        tecla_n  = {fila, col};
                        valido_n = 1'b1;
                        pres_n   = 1'b1;
                        estado_n = SOSTENIDA;
                    end else begin
                        cuenta_n = cuenta + 4'd1;
                    end
                end
                SOSTENIDA: begin
                    // Count reused as the consecutive-release counter.
                    if (!fila_sel_alta) begin
                        cuenta_n = 4'd0;
                    end else if (cuenta == 4'(DEB_TICKS - 1)) begin
                        cuenta_n = 4'd0;
                        pres_n   = 1'b0;
                        col_n    = col + 2'd1;
                        estado_n = BARRIDO;
                    end else begin
                        cuenta_n = cuenta + 4'd1;
                    end
                end
                default: estado_n = BARRIDO;
            endcase
        end
    end

    assign bus.columnas   = ~(4'b0001 << col);
    assign bus.tecla      = tecla_q;
    assign bus.valido     = valido_q;
    assign bus.presionada = pres_q;
endmodule

// File: tb/tb_lector_teclado.sv
// Directed-plus-random bench for lector_teclado with a behavioural keypad and
// an event-level expectation model (pulse counts, key codes, scan order).
module tb_lector_teclado;
    localparam int SD = 4;
    localparam int DT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] keys = 16'h0;
    logic [3:0]  filas_mod;

    int total = 0;
    int fails = 0;
    int vcount = 0;
    int presbad = 0;
    int colbad = 0;
    int cyc = 0;
    int last_pulse = -1;
    int min_gap = 1000000;
    logic [3:0] last_tecla = 4'h0;

    lector_teclado_if ifc();

    lector_teclado #(.SCAN_DIV(SD), .DEB_TICKS(DT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        filas_mod = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !ifc.columnas[c]) filas_mod[r] = 1'b0;
    end
    assign ifc.filas = filas_mod;

    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if ($countones(~ifc.columnas) != 1) colbad++;
            if (ifc.valido) begin
                vcount++;
                last_tecla = ifc.tecla;
                if (!ifc.presionada) presbad++;
                if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
                last_pulse = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press_release(input int k);
        int base;
        base = vcount;
        keys = 16'h0;
        keys[k] = 1'b1;
        wait_clks(100);
        check("press_count", vcount - base, 1);
        check("press_tecla", last_tecla, k);
        check("press_held", ifc.presionada, 1);
        keys = 16'h0;
        wait_clks(6);
        check("release_early", ifc.presionada, 1);
        wait_clks(40);
        check("release_late", ifc.presionada, 0);
        check("release_nopulse", vcount - base, 1);
    endtask

    initial begin
        int base, k, c;
        logic [3:0] e, prev;
        bit found;

        // Reset state
        #1 rst = 1'b1;
        wait_clks(3);
        check("rst_columnas", ifc.columnas, 4'b1110);
        check("rst_tecla", ifc.tecla, 0);
        check("rst_valido", ifc.valido, 0);
        check("rst_presionada", ifc.presionada, 0);

        // Idle scan: column index advances once per SD clocks after release of reset
        base = vcount;
        rst = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            wait_clks(1);
            e = ~(4'b0001 << ((n / SD) % 4));
            check("idle_columnas", ifc.columnas, e);
        end
        check("idle_novalido", vcount - base, 0);

        // Directed row 2 / column 1
        press_release(2*4 + 1);

        // Random keys
        for (int i = 0; i < 6; i++) press_release($urandom_range(0, 15));

        // Two rows in column 0 at once: lowest row wins
        base = vcount;
        keys = 16'h0;
        keys[1*4+0] = 1'b1;
        keys[3*4+0] = 1'b1;
        wait_clks(100);
        check("multi_count", vcount - base, 1);
        check("multi_tecla", last_tecla, 4'b0100);
        keys = 16'h0;
        wait_clks(40);

        // Bounce on row 0 / column 3: low for one tick only
        base = vcount;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            wait_clks(1);
            if (ifc.columnas == 4'b0111) found = 1;
        end
        check("bounce_found_col", found, 1);
        keys[3] = 1'b1;
        wait_clks(SD);
        keys = 16'h0;
        wait_clks(20);
        check("bounce_nopulse", vcount - base, 0);
        keys[3] = 1'b1;
        wait_clks(100);
        check("bounce_count", vcount - base, 1);
        check("bounce_tecla", last_tecla, 4'b0011);
        keys = 16'h0;
        wait_clks(40);

        // Reset one tick before debounce completes
        k = $urandom_range(0, 15);
        c = k % 4;
        base = vcount;
        found = 0;
        prev = ifc.columnas;
        for (int i = 0; i < 40 && !found; i++) begin
            wait_clks(1);
            if (!ifc.columnas[c] && prev[c]) found = 1;
            prev = ifc.columnas;
        end
        check("abort_found_col", found, 1);
        keys[k] = 1'b1;
        wait_clks(2*SD + 1);
        rst = 1'b1;
        #1;
        check("abort_columnas", ifc.columnas, 4'b1110);
        check("abort_tecla", ifc.tecla, 0);
        check("abort_valido", ifc.valido, 0);
        check("abort_nopulse", vcount - base, 0);
        wait_clks(3);
        rst = 1'b0;
        wait_clks(100);
        check("abort_recover_count", vcount - base, 1);
        check("abort_recover_tecla", last_tecla, k);
        check("abort_recover_held", ifc.presionada, 1);

        // Reset during hold
        rst = 1'b1;
        #1;
        check("hold_rst_presionada", ifc.presionada, 0);
        check("hold_rst_columnas", ifc.columnas, 4'b1110);
        check("hold_rst_tecla", ifc.tecla, 0);
        keys = 16'h0;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(40);

        // Release then re-press of the same key
        k = $urandom_range(0, 15);
        base = vcount;
        last_pulse = -1;
        min_gap = 1000000;
        keys[k] = 1'b1;
        wait_clks(100);
        keys = 16'h0;
        wait_clks(40);
        keys[k] = 1'b1;
        wait_clks(100);
        keys = 16'h0;
        wait_clks(40);
        check("repress_count", vcount - base, 2);
        check("repress_tecla", last_tecla, k);
        check("repress_gap", (min_gap >= 2*DT*SD), 1);

        check("columnas_onehot", colbad, 0);
        check("valido_with_presionada", presbad, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/lector_teclado.md
LECTOR_TECLADO -- requirements
Module: lector_teclado

Interface
REQ-001 Parameter SCAN_DIV, default 50000, SHALL be the clk cycles per scan tick (1 kHz at 50 MHz); legal values are >=4.
REQ-002 Parameter DEB_TICKS, default 4, SHALL be the number of consecutive matching samples required for press or release; legal values are 2..15.
REQ-003 clk  input  1  SHALL be the single system clock; every register is clocked on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 filas  input  4  SHALL be the keypad row lines: active-low, pulled up externally, asynchronous to clk.
REQ-006 columnas  output  4  SHALL be the keypad column drive: active-low, exactly one bit low at any time.
REQ-007 tecla  output  4  SHALL carry the key code {row index[1:0], column index[1:0]}.
REQ-008 valido  output  1  SHALL pulse high for exactly one clk per accepted press.
REQ-009 presionada  output  1  SHALL be high while an accepted key is held.

Function
REQ-010 filas SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value only.
REQ-011 An internal counter SHALL generate a one-clk tick every SCAN_DIV clks; the first tick SHALL occur SCAN_DIV clks after rst deasserts.
REQ-012 Rows SHALL be sampled only on tick clks; any column change SHALL take effect on the clk after the tick, leaving SCAN_DIV-1 clks of settle time.
REQ-013 The FSM SHALL have three states: BARRIDO, REBOTE and SOSTENIDA.
REQ-014 In BARRIDO with all sampled rows high at a tick, columnas SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110 (wrap-around).
REQ-015 In BARRIDO with any sampled row low at a tick, the FSM SHALL latch the row and column, set the debounce count to 1, hold columnas and go to REBOTE.
REQ-016 If several rows are low simultaneously, the lowest row index SHALL win; the other rows SHALL be ignored.
REQ-017 In REBOTE, at each tick where the latched row is low, the count SHALL increment.
REQ-018 In REBOTE, at a tick where the latched row is high, the FSM SHALL return to BARRIDO, clear the count and advance to the next column.
REQ-019 When the count reaches DEB_TICKS in REBOTE, on that same tick clk tecla SHALL update, valido SHALL pulse, presionada SHALL rise and the FSM SHALL go to SOSTENIDA.
REQ-020 In SOSTENIDA, columnas SHALL stay fixed and no further valido pulses SHALL be issued.
REQ-021 In SOSTENIDA, the FSM SHALL count consecutive ticks with the latched row high; any low sample SHALL reset this count to 0.
REQ-022 When the SOSTENIDA release count reaches DEB_TICKS, presionada SHALL fall on that tick clk, the FSM SHALL go to BARRIDO and columnas SHALL advance one column.
REQ-023 tecla SHALL hold its last accepted value until the next accepted press.
REQ-024 A second key pressed while in SOSTENIDA SHALL be ignored; it is detected only after release and rescan.

Reset
REQ-025 While rst=1: columnas=1110, tecla=0000, valido=0, presionada=0, FSM=BARRIDO, tick and debounce counters=0, synchronizer flops=1111.
REQ-026 Assertion of rst mid-debounce or mid-hold SHALL abort the operation with no valido pulse; after rst deasserts, scanning SHALL restart from column 0.

Verification (bench: SCAN_DIV=4, DEB_TICKS=3; keypad model shorts row r to column c while key (r,c) is pressed)
REQ-027 Idle: no key pressed, 40 clks after reset -> columnas cycles 1110, 1101, 1011, 0111, 1110 every 4 clks; valido never high.
REQ-028 Key row 2 / col 1 held 100 clks -> exactly one valido pulse with tecla=1001; presionada high from that pulse until the key is released and 3 high ticks elapse.
REQ-029 Bounce: key row 0 / col 3 is low for 1 tick, then high, then stable -> no valido on the first contact; a single valido with tecla=0011 after 3 consecutive low ticks.
REQ-030 Rows 1 and 3 pressed in column 0 simultaneously -> tecla=0100 and only one valido pulse.
REQ-031 rst asserted one tick before the count reaches DEB_TICKS -> no valido; outputs at reset values immediately (asynchronous); after rst deasserts and the key is still held, a normal press is accepted.
REQ-032 Release followed by re-press of the same key -> exactly two valido pulses, separated by at least 2*DEB_TICKS ticks.
